// File: rtl/cmac_tx_pkt_arbiter.sv
// cmac_tx_pkt_arbiter
// Packet-granular round-robin arbiter that lets two AXI-Stream requesters
// share the single CMAC/UDP transmit path. Once a port owns the path it keeps
// it until its tlast beat is accepted, so beats of different packets never
// interleave. A main + skid output register pair isolates upstream tready
// from downstream tready.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   arb_enable        1 = new packets may be granted (sampled only when idle)
//   s0_axis_*         requester 0 stream (tready is an output)
//   s1_axis_*         requester 1 stream (tready is an output)
//   m_axis_*          shared output stream (tready is an input)
//   grant             one-hot current owner, 00 when idle
//   pkt_count0/1      wrapping count of tlast beats accepted per port
//   busy              a packet is owned or the output stage holds data
module cmac_tx_pkt_arbiter #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arb_enable,

  input  logic                  s0_axis_tvalid,
  output logic                  s0_axis_tready,
  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s0_axis_tkeep,
  input  logic                  s0_axis_tlast,
  input  logic [USER_WIDTH-1:0] s0_axis_tuser,

  input  logic                  s1_axis_tvalid,
  output logic                  s1_axis_tready,
  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s1_axis_tkeep,
  input  logic                  s1_axis_tlast,
  input  logic [USER_WIDTH-1:0] s1_axis_tuser,

  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,

  output logic [1:0]            grant,
  output logic [CNT_WIDTH-1:0]  pkt_count0,
  output logic [CNT_WIDTH-1:0]  pkt_count1,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;

  logic                  main_valid;
  logic [DATA_WIDTH-1:0] main_data;
  logic [KEEP_WIDTH-1:0] main_keep;
  logic                  main_last;
  logic [USER_WIDTH-1:0] main_user;

  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;
  logic [KEEP_WIDTH-1:0] skid_keep;
  logic                  skid_last;
  logic [USER_WIDTH-1:0] skid_user;

  logic                  acc0;
  logic                  acc1;
  logic                  acc;
  logic                  drain;
  logic [DATA_WIDTH-1:0] in_data;
  logic [KEEP_WIDTH-1:0] in_keep;
  logic                  in_last;
  logic [USER_WIDTH-1:0] in_user;

  // Upstream ready is a function of registered state only: the owner may
  // push whenever the skid slot is free, which guarantees room for one beat
  // even if main does not drain this cycle.
  assign s0_axis_tready = (state == LOCK0) && !skid_valid;
  assign s1_axis_tready = (state == LOCK1) && !skid_valid;

  assign acc0  = s0_axis_tvalid && s0_axis_tready;
  assign acc1  = s1_axis_tvalid && s1_axis_tready;
  assign acc   = acc0 || acc1;
  assign drain = main_valid && m_axis_tready;

  // Select the owner's beat; only the owner can be accepted.
  always_comb begin
    in_data = s0_axis_tdata;
    in_keep = s0_axis_tkeep;
    in_last = s0_axis_tlast;
    in_user = s0_axis_tuser;
    if (state == LOCK1) begin
      in_data = s1_axis_tdata;
      in_keep = s1_axis_tkeep;
      in_last = s1_axis_tlast;
      in_user = s1_axis_tuser;
    end
  end

  // Arbitration FSM. Requests are only considered in IDLE, so after a tlast
  // there is always one IDLE cycle before the next grant. On contention the
  // port that did not send the previous packet wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 2'b00;
      pkt_count0 <= '0;
      pkt_count1 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_enable) begin
            if (s0_axis_tvalid && s1_axis_tvalid) begin
              if (last_grant) begin
                state <= LOCK0;
                grant <= 2'b01;
              end else begin
                state <= LOCK1;
                grant <= 2'b10;
              end
            end else if (s0_axis_tvalid) begin
              state <= LOCK0;
              grant <= 2'b01;
            end else if (s1_axis_tvalid) begin
              state <= LOCK1;
              grant <= 2'b10;
            end
          end
        end
        LOCK0: begin
          if (acc0 && s0_axis_tlast) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_grant <= 1'b0;
            pkt_count0 <= pkt_count0 + 1'b1;
          end
        end
        LOCK1: begin
          if (acc1 && s1_axis_tlast) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_grant <= 1'b1;
            pkt_count1 <= pkt_count1 + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  // Main/skid output stage. Main feeds m_axis directly. A new beat goes to
  // main when main is empty or draining; otherwise it parks in skid, which
  // refills main on the next drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_keep  <= '0;
      main_last  <= 1'b0;
      main_user  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_keep  <= '0;
      skid_last  <= 1'b0;
      skid_user  <= '0;
    end else begin
      if (drain) begin
        if (skid_valid) begin
          main_data  <= skid_data;
          main_keep  <= skid_keep;
          main_last  <= skid_last;
          main_user  <= skid_user;
          skid_valid <= 1'b0;
        end else if (acc) begin
          main_data <= in_data;
          main_keep <= in_keep;
          main_last <= in_last;
          main_user <= in_user;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (acc) begin
        if (!main_valid) begin
          main_valid <= 1'b1;
          main_data  <= in_data;
          main_keep  <= in_keep;
          main_last  <= in_last;
          main_user  <= in_user;
        end else begin
          skid_valid <= 1'b1;
          skid_data  <= in_data;
          skid_keep  <= in_keep;
          skid_last  <= in_last;
          skid_user  <= in_user;
        end
      end
    end
  end

  assign m_axis_tvalid = main_valid;
  assign m_axis_tdata  = main_data;
  assign m_axis_tkeep  = main_keep;
  assign m_axis_tlast  = main_last;
  assign m_axis_tuser  = main_user;

  assign busy = (state != IDLE) || main_valid || skid_valid;

endmodule

// File: doc/cmac_tx_pkt_arbiter.md
# cmac_tx_pkt_arbiter

Packet-granular round-robin arbiter that shares the single 512-bit CMAC/UDP transmit AXI-Stream path between two requesters, e.g. the XDMA H2C stream and the perf-monitor packet generator. It sits on the shared clock domain upstream of the cross-die TX buffer. It never interleaves beats of different packets. A registered skid output stage breaks the combinational path from downstream tready to upstream tready.

## Interface
- DATA_WIDTH, 512, tdata width
- KEEP_WIDTH, 64, tkeep width (DATA_WIDTH/8)
- USER_WIDTH, 1, tuser width
- CNT_WIDTH, 32, packet counter width
- CLK  in  1  clock; all logic on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- arb_enable  in  1  1 = new packets may be granted; 0 = finish current packet, then grant nothing
- s0_axis_{tvalid,tready,tdata,tkeep,tlast,tuser}  in/out(tready)/in  1/1/DATA_WIDTH/KEEP_WIDTH/1/USER_WIDTH  requester 0 stream
- s1_axis_{tvalid,tready,tdata,tkeep,tlast,tuser}  same as s0  requester 1 stream
- m_axis_{tvalid,tready,tdata,tkeep,tlast,tuser}  out/in(tready)/out  same widths  shared output stream
- grant  out  2  one-hot current owner; 00 when IDLE
- pkt_count0, pkt_count1  out  CNT_WIDTH  packets (tlast beats) accepted from s0 / s1
- busy  out  1  1 when state ≠ IDLE or output stage holds data

## Operation
- FSM states:
  - IDLE
  - LOCK0 (s0 owns the path)
  - LOCK1 (s1 owns the path)
- IDLE transitions, with arb_enable=1:
  - only s0_tvalid → LOCK0
  - only s1_tvalid → LOCK1
  - both valid → the port ≠ last_grant. last_grant resets to 1, so s0 wins the first contention.
- IDLE with arb_enable=0 → stay IDLE regardless of tvalid.
- LOCKx:
  - sx_tready = !skid_valid; s(other)_tready = 0.
  - On an accepted beat with tlast=1: next state IDLE, last_grant ← x, pkt_countx += 1.
- arb_enable is sampled only in IDLE. Deasserting it mid-packet does not truncate the packet.
- Output stage = main register + skid register.
  - An accepted beat loads main if main is empty or draining this cycle; otherwise it loads skid.
  - Skid moves to main when main drains.
- m_axis fields come straight from main. Beats pass through unmodified, including all-zero tkeep and any tuser.
- Counters wrap from 2^CNT_WIDTH−1 to 0 with no saturation.
- Packets of one beat (tlast on the first beat) are legal.

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE, last_grant=1, grant=00, busy=0
  - m_axis_tvalid=0; m_axis_tdata/tkeep/tlast/tuser=0
  - s0_tready=s1_tready=0
  - pkt_count0=pkt_count1=0
- Arbitration latency: IDLE sees tvalid in cycle N; grant and sx_tready assert in cycle N+1.
- Data latency: a beat accepted in cycle N is on m_axis in cycle N+1.
- Throughput:
  - one beat per cycle within a packet;
  - exactly one idle input cycle between consecutive packets (the IDLE cycle).
- Handshakes:
  - sx_tready depends only on registered state. It never depends combinationally on m_axis_tready or on sx_tvalid.
  - While m_axis_tvalid=1 and m_axis_tready=0, all m_axis signals hold stable.
  - With m_axis_tready held low, at most 2 beats are accepted (main + skid); then tready drops.
- Simultaneous events:
  - A tlast accept and a new request in the same cycle: the new request is arbitrated in the following IDLE cycle, not in the tlast cycle.
  - Both ports requesting every packet strictly alternate.
- Reset mid-packet: in-flight beats are discarded and the downstream sees a truncated packet. This is accepted behaviour; recovery is the downstream MAC's responsibility.

## Test plan
- Single port traffic: s0 sends 3 packets of 4 beats, m_axis_tready=1 → m_axis carries 12 beats in order, first beat 2 cycles after s0_tvalid, 1 bubble between packets; pkt_count0=3, pkt_count1=0.
- Contention after reset: s0 and s1 both hold 2-beat packets valid continuously → output order s0,s1,s0,s1; grant toggles 01,10; no beat from s1 appears between s0's first beat and its tlast.
- Backpressure: s1 sends 8-beat packet while m_axis_tready toggles 1,0,0,1,… → s1_tready drops after 2 unconsumed beats; all 8 beats arrive intact, m_axis stable during every stall.
- Enable gating: arb_enable falls on beat 2 of a 5-beat s0 packet → all 5 beats delivered; then grant=00 with s0/s1 tvalid high; arb_enable rises → next grant goes to s1.
- Counter wrap and edge packets: CNT_WIDTH=4, s0 sends 17 one-beat packets with tkeep=0 on some → all forwarded unchanged, pkt_count0 reads 1 after wrap.
- Async reset: RST_N pulses low mid-packet, between clock edges → m_axis_tvalid, grant, counters are 0 before the next edge; after release the first request arbitrates normally.
